// File: rtl/dct_transpose_4x4.sv
// Ping-pong transpose buffer between the column and row passes of the HEVC 4x4 forward DCT.
// Define DCT_TRANSPOSE_SAT_EN to saturate scaled coefficients instead of wrapping them.
module dct_transpose_4x4 #(
  parameter int WIDTH_IN  = 22,
  parameter int WIDTH_OUT = 16,
  parameter int SHIFT     = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH_IN-1:0]  d0,
  input  logic [WIDTH_IN-1:0]  d1,
  input  logic [WIDTH_IN-1:0]  d2,
  input  logic [WIDTH_IN-1:0]  d3,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH_OUT-1:0] q0,
  output logic [WIDTH_OUT-1:0] q1,
  output logic [WIDTH_OUT-1:0] q2,
  output logic [WIDTH_OUT-1:0] q3,
  output logic                 out_last
);

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

  localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [WIDTH_IN:0] RND = (SHIFT > 0) ? ((WIDTH_IN+1)'(1) << RND_POS) : '0;
`ifdef DCT_TRANSPOSE_SAT_EN
  localparam logic signed [WIDTH_IN:0] SAT_MAX = {{(WIDTH_IN-WIDTH_OUT+2){1'b0}}, {(WIDTH_OUT-1){1'b1}}};
  localparam logic signed [WIDTH_IN:0] SAT_MIN = {{(WIDTH_IN-WIDTH_OUT+2){1'b1}}, {(WIDTH_OUT-1){1'b0}}};
`endif

  logic [WIDTH_IN-1:0]  din    [4];
  logic [WIDTH_OUT-1:0] s_row  [4];
  logic [WIDTH_OUT-1:0] mem    [2][4][4];

  logic       wr_bank_reg;
  logic [1:0] wr_row_reg;
  logic [1:0] full_reg, full_next;
  logic       accept;

  state_t     state_reg, state_next;
  logic       rd_bank_reg, rd_bank_next;
  logic [1:0] col_reg, col_next;
  logic       out_valid_reg, out_valid_next;
  logic       out_last_reg, out_last_next;
  logic [WIDTH_OUT-1:0] q_reg    [4];
  logic [WIDTH_OUT-1:0] col_data [4];
  logic       load, clr_full, ld_bank;
  logic [1:0] ld_col;

  assign din[0] = d0;
  assign din[1] = d1;
  assign din[2] = d2;
  assign din[3] = d3;

  // Round-half-up then arithmetic shift, one extra bit so the rounding add cannot overflow.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_scale
      logic signed [WIDTH_IN:0] ext;
      assign ext = signed'({din[gi][WIDTH_IN-1], din[gi]});
`ifdef DCT_TRANSPOSE_SAT_EN
      logic signed [WIDTH_IN:0] rounded;
      assign rounded   = (ext + RND) >>> SHIFT;
      assign s_row[gi] = (rounded > SAT_MAX) ? SAT_MAX[WIDTH_OUT-1:0] :
                         (rounded < SAT_MIN) ? SAT_MIN[WIDTH_OUT-1:0] :
                                               rounded[WIDTH_OUT-1:0];
`else
      assign s_row[gi] = WIDTH_OUT'((ext + RND) >>> SHIFT);
`endif
      assign col_data[gi] = mem[ld_bank][gi][ld_col];
    end
  endgenerate

  assign in_ready = !rst && !full_reg[wr_bank_reg];
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int j = 0; j < 4; j++) begin
        mem[wr_bank_reg][wr_row_reg][j] <= s_row[j];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank_reg <= 1'b0;
      wr_row_reg  <= 2'd0;
      full_reg    <= 2'b00;
    end else begin
      full_reg <= full_next;
      if (accept) begin
        wr_row_reg <= wr_row_reg + 2'd1;
        if (wr_row_reg == 2'd3) wr_bank_reg <= ~wr_bank_reg;
      end
    end
  end

  // Write and read always target different banks, so set and clear never collide.
  always_comb begin
    full_next = full_reg;
    if (accept && wr_row_reg == 2'd3) full_next[wr_bank_reg] = 1'b1;
    if (clr_full) full_next[rd_bank_reg] = 1'b0;
  end

  always_comb begin
    state_next     = state_reg;
    rd_bank_next   = rd_bank_reg;
    col_next       = col_reg;
    out_valid_next = out_valid_reg;
    out_last_next  = out_last_reg;
    load           = 1'b0;
    clr_full       = 1'b0;
    ld_bank        = rd_bank_reg;
    ld_col         = 2'd0;
    case (state_reg)
      IDLE: begin
        if (full_reg[rd_bank_reg]) begin
          state_next     = STREAM;
          col_next       = 2'd0;
          load           = 1'b1;
          out_valid_next = 1'b1;
          out_last_next  = 1'b0;
        end
      end
      STREAM: begin
        if (out_ready) begin
          if (col_reg != 2'd3) begin
            col_next      = col_reg + 2'd1;
            ld_col        = col_reg + 2'd1;
            load          = 1'b1;
            out_last_next = (col_reg == 2'd2);
          end else begin
            clr_full     = 1'b1;
            rd_bank_next = ~rd_bank_reg;
            col_next     = 2'd0;
            if (full_reg[~rd_bank_reg]) begin
              ld_bank       = ~rd_bank_reg;
              load          = 1'b1;
              out_last_next = 1'b0;
            end else begin
              state_next     = IDLE;
              out_valid_next = 1'b0;
              out_last_next  = 1'b0;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      rd_bank_reg   <= 1'b0;
      col_reg       <= 2'd0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      for (int j = 0; j < 4; j++) q_reg[j] <= '0;
    end else begin
      state_reg     <= state_next;
      rd_bank_reg   <= rd_bank_next;
      col_reg       <= col_next;
      out_valid_reg <= out_valid_next;
      out_last_reg  <= out_last_next;
      if (load) begin
        for (int j = 0; j < 4; j++) q_reg[j] <= col_data[j];
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_last  = out_last_reg;
  assign q0 = q_reg[0];
  assign q1 = q_reg[1];
  assign q2 = q_reg[2];
  assign q3 = q_reg[3];

endmodule

// File: tb/tb_dct_transpose_4x4.sv
// Directed bench for dct_transpose_4x4: transpose, scaling table, backpressure and mid-block reset.
// Overflow expectations follow DCT_TRANSPOSE_SAT_EN when it is defined for the build.
module tb_dct_transpose_4x4;
  localparam int WI = 22;
  localparam int WO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, out_valid, out_last;
  logic [WI-1:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
  logic [WO-1:0] q0, q1, q2, q3;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int d;
    int q;
  } sc_vec_t;
  sc_vec_t tbl [7];

  always #5 clk = ~clk;

  dct_transpose_4x4 dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .out_valid(out_valid), .out_ready(out_ready),
    .q0(q0), .q1(q1), .q2(q2), .q3(q3),
    .out_last(out_last)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out, expected handshake", name);
  endtask

  function automatic logic [63:0] pack4(input int a, input int b, input int c, input int e);
    return {16'(a), 16'(b), 16'(c), 16'(e)};
  endfunction

  function automatic logic [63:0] qbus();
    return {q0, q1, q2, q3};
  endfunction

  function automatic int bv(input int b, input int i, input int j);
    return 2 * (100 * b + 4 * i + j);
  endfunction

  task automatic drive_row(input int a, input int b, input int c, input int e);
    d0 = 22'(a); d1 = 22'(b); d2 = 22'(c); d3 = 22'(e);
  endtask

  task automatic set_row(input int r);
    drive_row(bv(10 + r / 4, r % 4, 0), bv(10 + r / 4, r % 4, 1),
              bv(10 + r / 4, r % 4, 2), bv(10 + r / 4, r % 4, 3));
  endtask

  task automatic push_row(input int a, input int b, input int c, input int e, input string name);
    int n;
    drive_row(a, b, c, e);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      tick;
      n++;
    end
    if (!in_ready) timeout(name);
    else tick;
    in_valid = 1'b0;
  endtask

  task automatic push_block(input int b);
    for (int i = 0; i < 4; i++)
      push_row(bv(b, i, 0), bv(b, i, 1), bv(b, i, 2), bv(b, i, 3), $sformatf("push blk%0d row%0d", b, i));
  endtask

  task automatic pull_col(input logic [63:0] exp, input logic exp_last, input string name);
    int n;
    out_ready = 1'b1;
    n = 0;
    while (!out_valid && n < 50) begin
      tick;
      n++;
    end
    if (!out_valid) begin
      timeout(name);
    end else begin
      chk(name, qbus(), exp);
      chk({name, " last"}, 64'(out_last), 64'(exp_last));
      tick;
    end
    out_ready = 1'b0;
  endtask

  task automatic pull_block(input int b);
    for (int k = 0; k < 4; k++)
      pull_col(pack4(100*b + k, 100*b + 4 + k, 100*b + 8 + k, 100*b + 12 + k), k == 3,
               $sformatf("blk%0d col%0d", b, k));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, got, cyc, n;
    int at [12];
    logic [63:0] held;
    bit seen, changed, any_valid;

    tbl[0] = '{d: 5,  q: 3};
    tbl[1] = '{d: -5, q: -2};
    tbl[2] = '{d: -1, q: 0};
    tbl[3] = '{d: 1,  q: 1};
    tbl[4] = '{d: 65533, q: 32767};
`ifdef DCT_TRANSPOSE_SAT_EN
    tbl[5] = '{d: 1048575,  q: 32767};
    tbl[6] = '{d: -1048576, q: -32768};
`else
    tbl[5] = '{d: 1048575,  q: 0};
    tbl[6] = '{d: -1048576, q: 0};
`endif

    // Reset state
    tick;
    tick;
    chk("rst in_ready", 64'(in_ready), 64'd0);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst out_last", 64'(out_last), 64'd0);
    chk("rst q", qbus(), 64'd0);
    rst = 1'b0;
    #1;
    chk("post-rst in_ready", 64'(in_ready), 64'd1);
    tick;

    // Transpose with latency check
    push_block(0);
    chk("latency same cycle out_valid", 64'(out_valid), 64'd0);
    tick;
    chk("latency next cycle out_valid", 64'(out_valid), 64'd1);
    pull_block(0);
    chk("idle after block out_valid", 64'(out_valid), 64'd0);

    // Scaling / rounding / overflow table
    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < 4; i++)
        push_row(tbl[v].d, tbl[v].d, tbl[v].d, tbl[v].d, $sformatf("push scale%0d row%0d", v, i));
      for (int k = 0; k < 4; k++)
        pull_col(pack4(tbl[v].q, tbl[v].q, tbl[v].q, tbl[v].q), k == 3,
                 $sformatf("scale d=%0d col%0d", tbl[v].d, k));
    end

    // Backpressure: out_ready low, rows offered continuously
    acc = 0; seen = 0; changed = 0; held = '0;
    set_row(0);
    in_valid = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (in_ready && acc < 12) begin
        tick;
        acc++;
        if (acc < 12) set_row(acc);
      end else begin
        tick;
      end
      if (out_valid) begin
        if (!seen) begin
          held = qbus();
          seen = 1;
        end else if (qbus() !== held) begin
          changed = 1;
        end
      end
    end
    chk("bp rows accepted", 64'(acc), 64'd8);
    chk("bp in_ready low", 64'(in_ready), 64'd0);
    chk("bp out_valid", 64'(out_valid), 64'd1);
    chk("bp held col0", held, pack4(1000, 1004, 1008, 1012));
    chk("bp col0 stable", 64'(changed), 64'd0);
    chk("bp out_last low", 64'(out_last), 64'd0);

    got = 0;
    fork
      begin
        n = 0;
        while (acc < 12 && n < 60) begin
          if (in_ready) begin
            tick;
            acc++;
            if (acc < 12) set_row(acc);
          end else begin
            tick;
          end
          n++;
        end
        in_valid = 1'b0;
      end
      begin
        out_ready = 1'b1;
        cyc = 0;
        while (got < 12 && cyc < 80) begin
          if (out_valid) begin
            chk($sformatf("bp stream col%0d", got), qbus(),
                pack4(1000 + 100*(got/4) + got%4, 1004 + 100*(got/4) + got%4,
                      1008 + 100*(got/4) + got%4, 1012 + 100*(got/4) + got%4));
            chk($sformatf("bp stream col%0d last", got), 64'(out_last), 64'(got % 4 == 3));
            at[got] = cyc;
            got++;
          end
          tick;
          cyc++;
        end
        out_ready = 1'b0;
      end
    join
    chk("bp columns received", 64'(got), 64'd12);
    chk("bp rows total", 64'(acc), 64'd12);
    if (got == 12) begin
      chk("bp block0 back-to-back", 64'(at[3] - at[0]), 64'd3);
      chk("bp no bubble blk0->blk1", 64'(at[4] - at[3]), 64'd1);
      chk("bp block1 back-to-back", 64'(at[7] - at[4]), 64'd3);
    end

    // Reset mid-block: partial block, then a complete-but-unread block
    for (int i = 0; i < 2; i++)
      push_row(bv(20, i, 0), bv(20, i, 1), bv(20, i, 2), bv(20, i, 3), $sformatf("push blk20 row%0d", i));
    rst = 1'b1;
    #1;
    chk("mid rst in_ready", 64'(in_ready), 64'd0);
    tick;
    rst = 1'b0;
    #1;
    chk("after rst1 in_ready", 64'(in_ready), 64'd1);
    chk("after rst1 out_valid", 64'(out_valid), 64'd0);
    tick;
    push_block(21);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    any_valid = 0;
    for (int c = 0; c < 6; c++) begin
      if (out_valid) any_valid = 1;
      tick;
    end
    chk("after rst2 no output", 64'(any_valid), 64'd0);
    push_block(22);
    pull_block(22);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dct_transpose_4x4.md
# dct_transpose_4x4

Transpose buffer between the first (column) and second (row) 4-point DCT butterfly passes of the HEVC 4x4 forward transform. It accepts four 22-bit first-stage result rows per block. Each coefficient is rounded, right-shifted and narrowed to 16 bits, and the block is emitted as four transposed columns ready for the second butterfly pass. Two banks (ping-pong) allow one block to be written while the previous block is read out, sustaining one row per cycle in and one column per cycle out.

## Interface
- WIDTH_IN, 22, signed width of first-stage coefficients.
- WIDTH_OUT, 16, signed width of second-stage inputs.
- SHIFT, 1, first-stage scaling shift (HEVC 8-bit: 1); legal range 0..8.

- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- in_valid  in  1  row d0..d3 present.
- in_ready  out  1  row accepted on an edge where in_valid && in_ready.
- d0, d1, d2, d3  in  WIDTH_IN each  row coefficients, two's complement.
- out_valid  out  1  column q0..q3 present.
- out_ready  in  1  column consumed on an edge where out_valid && out_ready.
- q0, q1, q2, q3  out  WIDTH_OUT each  transposed column, two's complement.
- out_last  out  1  high with column 3 of each block.

## Operation
- Storage: 2 banks × 4 rows × 4 coefficients, each WIDTH_OUT. Scaling is applied on write.
- Scaling per coefficient:
  - SHIFT>0: s = (d + 2^(SHIFT-1)) >>> SHIFT, computed at WIDTH_IN+1 bits.
  - SHIFT=0: s = d.
  - s is then narrowed per Configuration.
- Write side:
  - Pointer wr_bank, plus row counter wr_row 0..3.
  - Each accepted row is written to row wr_row of bank wr_bank.
  - On acceptance of row 3: set full[wr_bank], toggle wr_bank, clear wr_row.
- in_ready = !rst && !full[wr_bank].
- Read FSM states:
  - IDLE: if full[rd_bank], go to STREAM with col=0 and load the output register.
  - STREAM: presents column col, with q_i = bank[rd_bank].row[i][col].
    - On a handshake with col<3: col+1, next column loaded.
    - On a handshake with col=3: clear full[rd_bank] and toggle rd_bank.
      - If the other bank is already full, continue in STREAM with col=0 (no bubble).
      - Otherwise go to IDLE with out_valid=0.
- Output registers hold q, out_valid and out_last stable while out_valid && !out_ready.
- out_last = out_valid && col==3.
- Boundary conditions:
  - Both banks full: in_ready=0. Rows offered are ignored until a bank frees.
  - A bank freed at edge E is writable from the cycle after E.
  - A write and a read never address the same bank, so simultaneous row-in and column-out is always legal.
  - in_valid deasserted mid-block: wr_row holds, and the partial block waits indefinitely.
  - Reset mid-operation: all stored and partial blocks are discarded. No output is produced for them.

## Timing
- Reset values:
  - out_valid=0, out_last=0, q0..q3=0.
  - wr_bank=rd_bank=0, wr_row=0, full=00, FSM=IDLE.
  - in_ready is 0 during rst and 1 on the first cycle after.
- Latency: row 3 accepted at edge E → column 0 valid from edge E+1. Back-to-back blocks in STREAM add 0 cycles.
- Throughput: 4 rows per 4 cycles in and 4 columns per 4 cycles out, with in_valid and out_ready held high.
- All outputs are registered except in_ready, which is combinational from registered state only and has no path from in_valid or out_ready.

## Configuration
- DCT_TRANSPOSE_SAT_EN defined: s is saturated to [-2^(WIDTH_OUT-1), 2^(WIDTH_OUT-1)-1].
- DCT_TRANSPOSE_SAT_EN undefined: s is truncated to its low WIDTH_OUT bits (wraps). No saturation logic is instantiated.

## Test plan
- Transpose, SHIFT=1:
  - Stimulus: rows i=0..3 with d_j = 2·(4i+j).
  - Response: column k gives q0..q3 = k, 4+k, 8+k, 12+k. out_last only on k=3. Column 0 valid one cycle after row 3 accepted.
- Rounding, SHIFT=1: d=5 → 3; d=-5 → -2; d=-1 → 0; d=1 → 1.
- Overflow: d=1048575 (0x0FFFFF) → q=32767 with DCT_TRANSPOSE_SAT_EN. Without the macro, q=0.
- Backpressure:
  - Stimulus: 3 blocks streamed with in_valid=1 and out_ready=0.
  - Response: in_ready drops after 8 rows accepted. Column 0 of block 0 is held stable.
  - Then raise out_ready: 12 columns arrive in order with no bubble between blocks.
- Reset mid-block: rst pulsed after 2 rows of block 0 and 4 rows of block 1 → out_valid stays 0. The next full block is output correctly from bank 0.
